vedic_mul8_sequencer: RTL and testbench

//  Computes an 8x8 unsigned product by time-sharing one external 4x4 Vedic multiplier core.
//  The core is built from GDI half/full adders. The sequencer splits the operands into nibbles
//  and issues the four partial products AL*BL, AH*BL, AL*BH, AH*BH to the core, one per cycle.
//  It shift-accumulates the returned results into a 16-bit product.
//  It sits between the operand source (valid/ready) and the shared core.

---
 rtl/vedic_mul8_sequencer_pkg.sv | 39 +++
 rtl/vedic_mul8_sequencer_pp_accumulator.sv | 81 ++++++++
 rtl/vedic_mul8_sequencer.sv | 108 ++++++++++
 tb/tb_vedic_mul8_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/vedic_mul8_sequencer_pkg.sv
// Shared definitions for the 8x8 Vedic multiply sequencer.
// Contents: FSM state codes, datapath widths, the partial-product shift
// table and the tag record that travels beside each in-flight core result.
package vedic_mul8_sequencer_pkg;

    // FSM state encoding (2-bit)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int NIB_W  = 4;
    localparam int PP_W   = 8;
    localparam int PROD_W = 16;
    localparam int SH_W   = 4;

    // Left shift applied to partial product k before accumulation
    localparam logic [SH_W-1:0] SH_K0 = 4'd0;  // AL*BL
    localparam logic [SH_W-1:0] SH_K1 = 4'd4;  // AH*BL
    localparam logic [SH_W-1:0] SH_K2 = 4'd4;  // AL*BH
    localparam logic [SH_W-1:0] SH_K3 = 4'd8;  // AH*BH

    typedef struct packed {
        logic            vld;
        logic [SH_W-1:0] sh;
    } pp_tag_t;

    function automatic logic [SH_W-1:0] pp_shift(input logic [1:0] k);
        logic [SH_W-1:0] s;
        case (k)
            2'd0:    s = SH_K0;
            2'd1:    s = SH_K1;
            2'd2:    s = SH_K2;
            default: s = SH_K3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/vedic_mul8_sequencer_pp_accumulator.sv
// vedic_pp_accumulator: tag pipe plus 16-bit shift-add accumulator.
// Every issue pushes {valid, shift} into a MUL_LAT-deep pipe so the shift
// arrives together with the core result it belongs to.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   push_i         a partial product is issued to the core this cycle
//   shift_i        shift amount for that partial product
//   mul_p_i        core result (valid when the oldest tag is valid)
//   clear_i        zero the accumulator (new operation accepted)
//   flush_i        drop all in-flight tags and zero the accumulator
//   acc_o          accumulated product
//   empty_o        no tag remains behind the one emerging this cycle, so the
//                  accumulator is final after this clock edge
module vedic_pp_accumulator
    import vedic_mul8_sequencer_pkg::*;
#(
    parameter int MUL_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [SH_W-1:0]   shift_i,
    input  logic [PP_W-1:0]   mul_p_i,
    input  logic              clear_i,
    input  logic              flush_i,
    output logic [PROD_W-1:0] acc_o,
    output logic              empty_o
);

    logic              add_en;
    logic [SH_W-1:0]   add_sh;
    logic [PROD_W-1:0] acc_q, acc_d;

    generate
        if (MUL_LAT == 0) begin : g_comb
            // Combinational core: result belongs to the issue in this cycle
            assign add_en  = push_i;
            assign add_sh  = shift_i;
            assign empty_o = 1'b1;
        end else begin : g_pipe
            pp_tag_t [MUL_LAT-1:0] tag_q, tag_d;

            always_comb begin
                tag_d        = '0;
                tag_d[0].vld = push_i;
                tag_d[0].sh  = shift_i;
                for (int i = 1; i < MUL_LAT; i++) tag_d[i] = tag_q[i-1];
            end

            always_ff @(posedge clk_i) begin
                if (rst_i || flush_i) tag_q <= '0;
                else                  tag_q <= tag_d;
            end

            // The last stage is consumed this cycle; only younger stages
            // keep the accumulator from being final.
            always_comb begin
                empty_o = 1'b1;
                for (int i = 0; i < MUL_LAT - 1; i++)
                    if (tag_q[i].vld) empty_o = 1'b0;
            end

            assign add_en = tag_q[MUL_LAT-1].vld;
            assign add_sh = tag_q[MUL_LAT-1].sh;
        end
    endgenerate

    // Max 255*255 = 0xFE01 fits in 16 bits, so no overflow handling
    always_comb begin
        acc_d = clear_i ? '0 : acc_q;
        if (add_en) acc_d = acc_d + (PROD_W'(mul_p_i) << add_sh);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) acc_q <= '0;
        else                  acc_q <= acc_d;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/vedic_mul8_sequencer.sv
// vedic_mul8_sequencer: 8x8 unsigned multiply by time-sharing one external
// 4x4 core. Operands are split into nibbles and the four partial products
// AL*BL, AH*BL, AL*BH, AH*BH are issued one per cycle, then shift-added.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   in_valid_i/in_ready_o        operand handshake, a_i/b_i operands
//   out_valid_o/out_ready_i      product handshake, product_o = a*b
//   busy_o                       FSM not in IDLE
//   mul_issue_o, mul_a_o, mul_b_o  request to the shared core
//   mul_p_i                      core result, MUL_LAT cycles after issue
module vedic_mul8_sequencer
    import vedic_mul8_sequencer_pkg::*;
#(
    parameter int MUL_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [7:0]        a_i,
    input  logic [7:0]        b_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [PROD_W-1:0] product_o,
    output logic              busy_o,
    output logic              mul_issue_o,
    output logic [NIB_W-1:0]  mul_a_o,
    output logic [NIB_W-1:0]  mul_b_o,
    input  logic [PP_W-1:0]   mul_p_i
);

    // With a combinational core there is nothing to wait for after k=3
    localparam logic [1:0] ST_AFTER_ISSUE = (MUL_LAT > 0) ? ST_DRAIN : ST_DONE;

    logic [1:0]        state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [7:0]        a_q, a_d, b_q, b_d;
    logic              accept, issue, acc_empty;
    logic [PROD_W-1:0] acc;

    assign accept = (state_q == ST_IDLE) && in_valid_i;
    assign issue  = (state_q == ST_ISSUE);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    k_d     = 2'd0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) state_d = ST_AFTER_ISSUE;
            end
            ST_DRAIN: begin
                if (acc_empty) state_d = ST_DONE;
            end
            default: begin
                if (out_ready_i) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            k_q     <= 2'd0;
            a_q     <= 8'd0;
            b_q     <= 8'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // k[0] selects the high nibble of a, k[1] the high nibble of b
    assign mul_issue_o = issue;
    assign mul_a_o     = !issue ? '0 : (k_q[0] ? a_q[7:4] : a_q[3:0]);
    assign mul_b_o     = !issue ? '0 : (k_q[1] ? b_q[7:4] : b_q[3:0]);

    vedic_pp_accumulator #(.MUL_LAT(MUL_LAT)) u_acc (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (issue),
        .shift_i (pp_shift(k_q)),
        .mul_p_i (mul_p_i),
        .clear_i (accept),
        .flush_i (rst_i),
        .acc_o   (acc),
        .empty_o (acc_empty)
    );

    // in_ready must already read 0 in the reset cycle itself
    assign in_ready_o  = (state_q == ST_IDLE) && !rst_i;
    assign busy_o      = (state_q != ST_IDLE);
    assign out_valid_o = (state_q == ST_DONE);
    assign product_o   = out_valid_o ? acc : '0;

endmodule

// File: tb/tb_vedic_mul8_sequencer.sv
// Bench for vedic_mul8_sequencer: three DUTs (MUL_LAT 0, 1, 3) each with a
// behavioural 4x4 core and a cycle-level reference model of the handshake
// timing and product value.
module tb_vedic_mul8_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int lat, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL lat%0d %s: got %0h expected %0h", lat, nm, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int LAT = (g == 0) ? 0 : (g == 1) ? 1 : 3;

        logic        rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
        logic [7:0]  a = 8'd0, b = 8'd0;
        logic        in_ready, out_valid, busy, mul_issue;
        logic [15:0] product;
        logic [3:0]  mul_a, mul_b;
        logic [7:0]  mul_p;
        bit          fin = 1'b0, b2b = 1'b0;

        vedic_mul8_sequencer #(.MUL_LAT(LAT)) dut (
            .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
            .a_i(a), .b_i(b), .out_valid_o(out_valid), .out_ready_i(out_ready),
            .product_o(product), .busy_o(busy), .mul_issue_o(mul_issue),
            .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_p_i(mul_p)
        );

        // Behavioural core; garbage on non-issue slots exposes untagged adds
        if (LAT == 0) begin : core0
            assign mul_p = 8'(mul_a) * 8'(mul_b);
        end else begin : coreN
            logic [7:0] pq [LAT];
            always @(posedge clk) begin
                pq[0] <= mul_issue ? 8'(mul_a) * 8'(mul_b) : 8'($urandom);
                for (int i = 1; i < LAT; i++) pq[i] <= pq[i-1];
            end
            assign mul_p = pq[LAT-1];
        end

        // Reference model: t = cycles since accept (1..4 issue, >=5+LAT done)
        int          cyc = 0, t = 0;
        bit          m_busy = 1'b0, started = 1'b0;
        logic [7:0]  ma = 8'd0, mb = 8'd0;
        logic [15:0] mexp = 16'd0;

        always @(posedge clk) begin
            cyc     <= cyc + 1;
            started <= started | rst;
            if (rst) begin
                m_busy <= 1'b0;
                t      <= 0;
            end else if (!m_busy) begin
                if (in_valid) begin
                    m_busy <= 1'b1;
                    t      <= 1;
                    ma     <= a;
                    mb     <= b;
                    mexp   <= 16'(a) * 16'(b);
                end
            end else if (t >= LAT + 5 && out_ready) begin
                m_busy <= 1'b0;
                t      <= 0;
            end else begin
                t <= t + 1;
            end
        end

        // Per-cycle comparison against the model
        always @(negedge clk) begin
            automatic logic [7:0] eab;
            automatic bit e_iss, e_done;
            e_iss  = m_busy && t >= 1 && t <= 4;
            e_done = m_busy && t >= LAT + 5;
            eab    = 8'h00;
            if (e_iss) begin
                case (t)
                    1:       eab = {ma[3:0], mb[3:0]};
                    2:       eab = {ma[7:4], mb[3:0]};
                    3:       eab = {ma[3:0], mb[7:4]};
                    default: eab = {ma[7:4], mb[7:4]};
                endcase
            end
            if (started) begin
                chk("in_ready", LAT, in_ready, !m_busy && !rst);
                chk("busy", LAT, busy, m_busy);
                chk("mul_issue", LAT, mul_issue, e_iss);
                chk("mul_ab", LAT, {mul_a, mul_b}, eab);
                chk("out_valid", LAT, out_valid, e_done);
                if (e_done) chk("product", LAT, product, mexp);
            end
        end

        // Observed per-op bookkeeping: issue order, latency, spacing
        int          acc_cyc = 0, prev_acc = 0, iss_cnt = 0;
        bit          have_prev = 1'b0, ov_q = 1'b0;
        logic [31:0] seq = 32'd0;
        logic [15:0] last_prod = 16'd0;

        always @(negedge clk) begin
            if (started && !rst) begin
                if (in_valid && in_ready) begin
                    if (b2b && have_prev) chk("accept_spacing", LAT, cyc - prev_acc, LAT + 6);
                    prev_acc  <= cyc;
                    have_prev <= b2b;
                    acc_cyc   <= cyc;
                    iss_cnt   <= 0;
                    seq       <= 32'd0;
                end else if (!b2b) begin
                    have_prev <= 1'b0;
                end
                if (mul_issue) begin
                    iss_cnt <= iss_cnt + 1;
                    seq     <= {seq[23:0], mul_a, mul_b};
                end
                if (out_valid && !ov_q) begin
                    chk("issue_count", LAT, iss_cnt, 4);
                    chk("accept_to_valid", LAT, cyc - acc_cyc, LAT + 5);
                    last_prod <= product;
                end
                ov_q <= out_valid;
            end
        end

        // Called at posedge+1 with the model idle; returns idle again
        task automatic op(input logic [7:0] x, input logic [7:0] y, input bit bp);
            in_valid = 1'b1; a = x; b = y;
            @(posedge clk); #1;
            in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom);
            for (int i = 0; i < 20 && !(m_busy && t >= LAT + 5); i++) begin
                @(posedge clk); #1;
            end
            if (bp) begin
                for (int i = 0; i < 5; i++) begin
                    in_valid = (i == 1); a = 8'($urandom); b = 8'($urandom);
                    @(posedge clk); #1;
                end
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        endtask

        initial begin
            int nacc;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0; out_ready = 1'b1;

            op(8'hFF, 8'hFF, 1'b0); chk("p_FFxFF", LAT, last_prod, 16'hFE01);
            op(8'h00, 8'hA5, 1'b0); chk("p_00xA5", LAT, last_prod, 16'h0000);
            op(8'h12, 8'h34, 1'b0); chk("p_12x34", LAT, last_prod, 16'h03A8);
            chk("nib_seq", LAT, seq, 32'h24142313);

            out_ready = 1'b0;
            op(8'h9C, 8'h7B, 1'b1); chk("p_bp", LAT, last_prod, 16'h4AF4);

            // Abort in the k=2 issue cycle
            in_valid = 1'b1; a = 8'hC7; b = 8'hE9;
            @(posedge clk); #1; in_valid = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1; rst = 1'b0;
            chk("busy_after_rst", LAT, busy, 1'b0);
            op(8'h03, 8'h05, 1'b0); chk("p_after_rst", LAT, last_prod, 16'h000F);

            // Back-to-back random traffic
            b2b = 1'b1; in_valid = 1'b1; nacc = 0;
            for (int c = 0; c < 20000 && nacc < 1000; c++) begin
                a = 8'($urandom); b = 8'($urandom);
                @(posedge clk); #1;
                if (m_busy && t == 1) nacc++;
            end
            in_valid = 1'b0;
            for (int c = 0; c < 30 && m_busy; c++) begin
                @(posedge clk); #1;
            end
            b2b = 1'b0;
            fin = 1'b1;
        end
    end

    initial begin
        int c;
        c = 0;
        while (!(lane[0].fin && lane[1].fin && lane[2].fin) && c < 40000) begin
            @(posedge clk);
            c++;
        end
        if (c >= 40000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got %0d cycles expected lanes finished", c);
        end
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
